drive_sequencer: RTL and testbench
==================================

Name: drive_sequencer

Overview:
- Sits between the command sources (manual remote decoder, autonomous planner) and the dual motor driver.
- Arbitrates the two one-hot direction requests over a valid/ack handshake.
- Inserts an IDLE dead-time on every change between two non-IDLE directions.
- Generates a soft-start PWM duty value for ACC/DEC and stops the car on command loss (watchdog).

Parameters:
- DEADTIME_CYC, 125000, cycles direction is held IDLE between two different non-IDLE directions (1 ms).
- TIMEOUT_CYC, 12500000, cycles without an accepted command before forced stop (100 ms).
- RAMP_DIV, 125000, cycles per duty increment during ACC/DEC.
- DUTY_W, 8, duty width.
- DUTY_MIN, 64, duty loaded on entry to ACC/DEC.

Ports:
- clk_125mhz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- man_valid  in  1  manual command valid; held until man_ack.
- man_cmd  in  7  manual one-hot direction; stable while man_valid.
- auto_valid  in  1  autonomous command valid; held until auto_ack.
- auto_cmd  in  7  autonomous one-hot direction.
- direction  out  7  one-hot code to the motor driver.
- duty  out  DUTY_W  duty value to the PWM generator.
- man_ack  out  1  one-cycle pulse: man_cmd accepted.
- auto_ack  out  1  one-cycle pulse: auto_cmd accepted.
- dead_active  out  1  high while in ST_DEAD.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Encoding: FORWARD=0000001, IDLE=0000010, BACKWARD=0000100, LEFT=0001000, RIGHT=0010000, ACC=0100000, DEC=1000000. Any other value (zero or multi-hot) is accepted and treated as IDLE.
- Reset (async, immediate, including mid-dead-time): direction=IDLE, duty=0, acks=0, dead_active=0, timeout=0, state=ST_STOP, all counters=0, cur=IDLE.
- Arbitration: manual has fixed priority. Auto is accepted only when man_valid=0.
- Acceptance is allowed only in ST_STOP or ST_DRIVE, and only when neither ack was high in the previous cycle.
- Nothing is accepted in ST_DEAD; sources stall with valid held.
- Accept timing: on the accepting edge, the ack register goes high for exactly 1 cycle and the state/direction update happens on that same edge (latency 1 clock from valid sampled).
- States:
  - ST_STOP: direction=IDLE.
    - Accept non-IDLE → ST_DRIVE, direction=cmd on the same edge (no dead-time).
    - Accept IDLE → stay.
  - ST_DRIVE: direction=cur.
    - Accept cmd==cur → stay, watchdog cleared, ramp not restarted.
    - Accept IDLE → ST_STOP.
    - Accept other non-IDLE → ST_DEAD, pending=cmd, direction=IDLE, dead counter=0.
  - ST_DEAD: direction=IDLE, dead_active=1. Counter increments each cycle. When counter==DEADTIME_CYC-1 → ST_DRIVE, direction=pending, so IDLE is driven for exactly DEADTIME_CYC cycles.
- Watchdog:
  - Counts cycles since last accept, in ST_DRIVE only; holds 0 in ST_STOP/ST_DEAD.
  - Reaching TIMEOUT_CYC → ST_STOP, direction=IDLE, timeout=1.
  - timeout clears on the next accept.
  - An accept in the same cycle as expiry wins: no timeout.
- Duty:
  - 0 in every direction except ACC/DEC.
  - Entering ACC or DEC (from STOP or after dead-time) loads DUTY_MIN.
  - Then +1 every RAMP_DIV cycles, saturating at 2^DUTY_W-1.
  - Ramp prescaler resets on entry.
- Counters are sized to hold their parameter. All outputs are registered.

Optional Feature:
- Macro SOFT_START_EN.
- Defined: duty ramps as above.
- Undefined: entering ACC/DEC loads duty = 2^DUTY_W-1 immediately, and the ramp prescaler is not built.
- All other behaviour is identical in both builds.

Test Plan:
- Parameters for all scenarios: DEADTIME_CYC=4, TIMEOUT_CYC=50, RAMP_DIV=2, DUTY_MIN=64.
- Reset, then man_valid with FORWARD → man_ack 1 cycle; direction=0000001 on the same edge; duty=0; dead_active=0.
- FORWARD active, auto sends BACKWARD → auto_ack pulse; direction=0000010 for exactly 4 cycles with dead_active=1; then 0000100. A manual request during the dead-time gets no ack until ST_DRIVE.
- man_valid and auto_valid asserted together (LEFT, RIGHT) from STOP → man_ack only; direction=0001000; auto_ack follows at the earliest legal cycle, then 4-cycle dead-time, then 0010000.
- From STOP, ACC with SOFT_START_EN defined → duty=64 on entry, then 65, 66… each 2 cycles, saturating at 255. Repeat ACC → ramp continues, no reload. Without the macro → duty=255 on entry.
- Drive FORWARD with no further commands for 50 cycles → direction=IDLE, timeout=1, state STOP. Next accepted command clears timeout. An accept on the expiry cycle → no timeout.
- Assert reset mid-dead-time and mid-ramp → outputs immediately at reset values. Illegal cmd 0000011 from DRIVE → acked, direction=IDLE, ST_STOP.

Source files
------------

// File: rtl/drive_sequencer.sv
// Direction sequencer for the dual motor driver: arbitrates manual/autonomous commands, inserts
// dead-time between opposing directions, generates the ACC/DEC duty and runs a command watchdog.
// Define SOFT_START_EN for a ramped duty on ACC/DEC; otherwise duty jumps straight to full scale.
module drive_sequencer #(
    parameter int unsigned DEADTIME_CYC = 125000,
    parameter int unsigned TIMEOUT_CYC  = 12500000,
    parameter int unsigned RAMP_DIV     = 125000,
    parameter int unsigned DUTY_W       = 8,
    parameter int unsigned DUTY_MIN     = 64
) (
    input  logic              clk_125mhz,
    input  logic              reset,
    input  logic              man_valid,
    input  logic [6:0]        man_cmd,
    input  logic              auto_valid,
    input  logic [6:0]        auto_cmd,
    output logic [6:0]        direction,
    output logic [DUTY_W-1:0] duty,
    output logic              man_ack,
    output logic              auto_ack,
    output logic              dead_active,
    output logic              timeout
);

    localparam logic [6:0] DIR_FWD  = 7'b0000001;
    localparam logic [6:0] DIR_IDLE = 7'b0000010;
    localparam logic [6:0] DIR_BWD  = 7'b0000100;
    localparam logic [6:0] DIR_LEFT = 7'b0001000;
    localparam logic [6:0] DIR_RGT  = 7'b0010000;
    localparam logic [6:0] DIR_ACC  = 7'b0100000;
    localparam logic [6:0] DIR_DEC  = 7'b1000000;

    localparam int unsigned DEAD_W = $clog2(DEADTIME_CYC + 1);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME_CYC - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX  = '1;

`ifdef SOFT_START_EN
    localparam int unsigned       RAMP_W     = $clog2(RAMP_DIV + 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(RAMP_DIV - 1);
    localparam logic [DUTY_W-1:0] DUTY_START = DUTY_W'(DUTY_MIN);
`else
    localparam logic [DUTY_W-1:0] DUTY_START = DUTY_MAX;
`endif

    typedef enum logic [1:0] {StStop, StDrive, StDead} state_e;

    state_e              state_q;
    logic [6:0]          cur_q;
    logic [6:0]          pend_q;
    logic [DEAD_W-1:0]   dead_cnt_q;
    logic [WDOG_W-1:0]   wdog_q;

    logic [6:0]          cmd_sel;
    logic [6:0]          cmd_norm;
    logic                can_accept;
    logic                take_man;
    logic                take_auto;
    logic                take;
    logic [DUTY_W-1:0]   duty_step;

    function automatic logic is_ramp(input logic [6:0] d);
        return (d == DIR_ACC) || (d == DIR_DEC);
    endfunction

    // Anything that is not a legal one-hot code collapses to IDLE.
    always_comb begin
        cmd_sel = man_valid ? man_cmd : auto_cmd;
        case (cmd_sel)
            DIR_FWD, DIR_IDLE, DIR_BWD, DIR_LEFT, DIR_RGT, DIR_ACC, DIR_DEC: cmd_norm = cmd_sel;
            default:                                                         cmd_norm = DIR_IDLE;
        endcase
    end

    // Blocking on the previous ack gives sources one cycle to drop valid.
    assign can_accept = (state_q != StDead) && !man_ack && !auto_ack;
    assign take_man   = can_accept && man_valid;
    assign take_auto  = can_accept && !man_valid && auto_valid;
    assign take       = take_man || take_auto;

`ifdef SOFT_START_EN
    logic [RAMP_W-1:0] ramp_cnt_q;
    logic [RAMP_W-1:0] ramp_cnt_d;

    always_comb begin
        ramp_cnt_d = ramp_cnt_q;
        duty_step  = duty;
        if (is_ramp(cur_q)) begin
            if (ramp_cnt_q == RAMP_LAST) begin
                ramp_cnt_d = '0;
                if (duty != DUTY_MAX) begin
                    duty_step = duty + 1'b1;
                end
            end else begin
                ramp_cnt_d = ramp_cnt_q + 1'b1;
            end
        end
    end

    // Held at zero outside DRIVE, so every entry into ACC/DEC starts a fresh prescaler period.
    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            ramp_cnt_q <= '0;
        end else if (state_q != StDrive) begin
            ramp_cnt_q <= '0;
        end else begin
            ramp_cnt_q <= ramp_cnt_d;
        end
    end
`else
    logic unused_ramp_cfg;
    assign unused_ramp_cfg = ^{RAMP_DIV, DUTY_MIN};
    assign duty_step       = duty;
`endif

    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            state_q     <= StStop;
            cur_q       <= DIR_IDLE;
            pend_q      <= DIR_IDLE;
            dead_cnt_q  <= '0;
            wdog_q      <= '0;
            direction   <= DIR_IDLE;
            duty        <= '0;
            man_ack     <= 1'b0;
            auto_ack    <= 1'b0;
            dead_active <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            man_ack  <= take_man;
            auto_ack <= take_auto;
            if (take) begin
                timeout <= 1'b0;
            end
            unique case (state_q)
                StStop: begin
                    wdog_q <= '0;
                    if (take && cmd_norm != DIR_IDLE) begin
                        state_q   <= StDrive;
                        cur_q     <= cmd_norm;
                        direction <= cmd_norm;
                        duty      <= is_ramp(cmd_norm) ? DUTY_START : '0;
                    end
                end
                StDrive: begin
                    if (take) begin
                        wdog_q <= '0;
                        if (cmd_norm == cur_q) begin
                            duty <= duty_step;
                        end else if (cmd_norm == DIR_IDLE) begin
                            state_q   <= StStop;
                            cur_q     <= DIR_IDLE;
                            direction <= DIR_IDLE;
                            duty      <= '0;
                        end else begin
                            state_q     <= StDead;
                            pend_q      <= cmd_norm;
                            cur_q       <= DIR_IDLE;
                            direction   <= DIR_IDLE;
                            duty        <= '0;
                            dead_cnt_q  <= '0;
                            dead_active <= 1'b1;
                        end
                    end else if (wdog_q == WDOG_LAST) begin
                        state_q   <= StStop;
                        cur_q     <= DIR_IDLE;
                        direction <= DIR_IDLE;
                        duty      <= '0;
                        wdog_q    <= '0;
                        timeout   <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                        duty   <= duty_step;
                    end
                end
                StDead: begin
                    wdog_q <= '0;
                    if (dead_cnt_q == DEAD_LAST) begin
                        state_q     <= StDrive;
                        cur_q       <= pend_q;
                        direction   <= pend_q;
                        duty        <= is_ramp(pend_q) ? DUTY_START : '0;
                        dead_cnt_q  <= '0;
                        dead_active <= 1'b0;
                    end else begin
                        dead_cnt_q <= dead_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StStop;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with shortened timing parameters.
module tb_drive_sequencer;

    localparam logic [6:0] FWD  = 7'b0000001;
    localparam logic [6:0] IDLE = 7'b0000010;
    localparam logic [6:0] BWD  = 7'b0000100;
    localparam logic [6:0] LEFT = 7'b0001000;
    localparam logic [6:0] RGT  = 7'b0010000;
    localparam logic [6:0] ACC  = 7'b0100000;

    logic       clk_125mhz = 1'b0;
    logic       reset      = 1'b1;
    logic       man_valid  = 1'b0;
    logic [6:0] man_cmd    = 7'b0;
    logic       auto_valid = 1'b0;
    logic [6:0] auto_cmd   = 7'b0;
    logic [6:0] direction;
    logic [7:0] duty;
    logic       man_ack;
    logic       auto_ack;
    logic       dead_active;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    drive_sequencer #(
        .DEADTIME_CYC (4),
        .TIMEOUT_CYC  (50),
        .RAMP_DIV     (2),
        .DUTY_W       (8),
        .DUTY_MIN     (64)
    ) u_dut (
        .clk_125mhz  (clk_125mhz),
        .reset       (reset),
        .man_valid   (man_valid),
        .man_cmd     (man_cmd),
        .auto_valid  (auto_valid),
        .auto_cmd    (auto_cmd),
        .direction   (direction),
        .duty        (duty),
        .man_ack     (man_ack),
        .auto_ack    (auto_ack),
        .dead_active (dead_active),
        .timeout     (timeout)
    );

    always #4 clk_125mhz = ~clk_125mhz;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_125mhz);
        #1;
    endtask

    // Raises valid, waits (bounded) for the ack, then drops valid; returns just after the ack edge.
    task automatic send(input logic is_man, input logic [6:0] cmd, input string tag);
        int n;
        if (is_man) begin
            man_valid = 1'b1;
            man_cmd   = cmd;
        end else begin
            auto_valid = 1'b1;
            auto_cmd   = cmd;
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!(is_man ? man_ack : auto_ack) && n < 20);
        check_eq(tag, is_man ? man_ack : auto_ack, 1'b1);
        man_valid  = 1'b0;
        auto_valid = 1'b0;
    endtask

    function automatic logic [31:0] exp_duty(input int k);
`ifdef SOFT_START_EN
        int v;
        v = 64 + k / 2;
        return (v > 255) ? 255 : v;
`else
        return 255;
`endif
    endfunction

    initial begin
        // Reset state
        tick();
        tick();
        check_eq("rst_dir", direction, IDLE);
        check_eq("rst_duty", duty, 0);
        check_eq("rst_acks", {man_ack, auto_ack}, 0);
        check_eq("rst_dead", dead_active, 0);
        check_eq("rst_tmo", timeout, 0);
        reset = 1'b0;
        tick();

        // First accept: ack and direction on the same edge
        man_valid = 1'b1;
        man_cmd   = FWD;
        tick();
        check_eq("fwd_ack", man_ack, 1);
        check_eq("fwd_dir", direction, FWD);
        check_eq("fwd_duty", duty, 0);
        check_eq("fwd_dead", dead_active, 0);
        man_valid = 1'b0;
        tick();
        check_eq("fwd_ack_pulse", man_ack, 0);

        // Direction change through dead-time; manual request stalls meanwhile
        auto_valid = 1'b1;
        auto_cmd   = BWD;
        tick();
        check_eq("bwd_ack", auto_ack, 1);
        auto_valid = 1'b0;
        man_valid  = 1'b1;
        man_cmd    = LEFT;
        for (int i = 0; i < 4; i++) begin
            check_eq("dead1_dir", direction, IDLE);
            check_eq("dead1_flag", dead_active, 1);
            check_eq("dead1_noack", man_ack, 0);
            tick();
        end
        check_eq("bwd_dir", direction, BWD);
        check_eq("bwd_dead_off", dead_active, 0);
        check_eq("bwd_noack", man_ack, 0);
        tick();
        check_eq("left_ack", man_ack, 1);
        check_eq("left_dead_dir", direction, IDLE);
        man_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("left_dir", direction, LEFT);

        // Back to STOP, then simultaneous requests
        send(1'b1, IDLE, "idle1_ack");
        check_eq("idle1_dir", direction, IDLE);
        tick();
        man_valid  = 1'b1;
        man_cmd    = LEFT;
        auto_valid = 1'b1;
        auto_cmd   = RGT;
        tick();
        check_eq("both_man_ack", man_ack, 1);
        check_eq("both_auto_ack", auto_ack, 0);
        check_eq("both_dir", direction, LEFT);
        man_valid = 1'b0;
        tick();
        check_eq("both_auto_blocked", auto_ack, 0);
        tick();
        check_eq("both_auto_ack2", auto_ack, 1);
        check_eq("both_dead", dead_active, 1);
        auto_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_eq("both_dead_last", direction, IDLE);
        tick();
        check_eq("both_rgt_dir", direction, RGT);

        // ACC ramp with continuous repeats (no reload)
        send(1'b1, IDLE, "idle2_ack");
        tick();
        man_valid = 1'b1;
        man_cmd   = ACC;
        tick();
        check_eq("acc_ack", man_ack, 1);
        check_eq("acc_dir", direction, ACC);
        check_eq("acc_duty0", duty, exp_duty(0));
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (k <= 4 || k == 200 || k == 400) begin
                check_eq($sformatf("acc_duty%0d", k), duty, exp_duty(k));
            end
        end
        check_eq("acc_dir_held", direction, ACC);
        man_valid = 1'b0;
        tick();
        send(1'b1, IDLE, "idle3_ack");
        check_eq("idle3_duty", duty, 0);
        tick();

        // Watchdog expiry, clear, and accept on the expiry cycle
        send(1'b1, FWD, "wd_fwd_ack");
        for (int i = 0; i < 49; i++) tick();
        check_eq("wd_hold_dir", direction, FWD);
        check_eq("wd_hold_tmo", timeout, 0);
        tick();
        check_eq("wd_exp_dir", direction, IDLE);
        check_eq("wd_exp_tmo", timeout, 1);
        send(1'b1, FWD, "wd_re_ack");
        check_eq("wd_clr_tmo", timeout, 0);
        check_eq("wd_re_dir", direction, FWD);
        for (int i = 0; i < 49; i++) tick();
        man_valid = 1'b1;
        man_cmd   = FWD;
        tick();
        check_eq("wd_race_ack", man_ack, 1);
        check_eq("wd_race_tmo", timeout, 0);
        check_eq("wd_race_dir", direction, FWD);
        man_valid = 1'b0;
        tick();
        check_eq("wd_race_dir2", direction, FWD);

        // Illegal command from DRIVE acts as IDLE
        send(1'b1, 7'b0000011, "ill_ack");
        check_eq("ill_dir", direction, IDLE);
        check_eq("ill_dead", dead_active, 0);
        tick();
        send(1'b1, LEFT, "ill_stop_ack");
        check_eq("ill_stop_dir", direction, LEFT);

        // Reset mid-dead-time
        send(1'b0, RGT, "rd_ack");
        tick();
        check_eq("rd_in_dead", dead_active, 1);
        reset = 1'b1;
        #1;
        check_eq("rd_dir", direction, IDLE);
        check_eq("rd_dead", dead_active, 0);
        check_eq("rd_acks", {man_ack, auto_ack}, 0);
        tick();
        reset = 1'b0;
        tick();
        send(1'b1, FWD, "rd_fwd_ack");
        check_eq("rd_fwd_dir", direction, FWD);
        tick();

        // Reset mid-ramp
        send(1'b1, IDLE, "rr_idle_ack");
        tick();
        send(1'b1, ACC, "rr_acc_ack");
        tick();
        tick();
        tick();
        check_eq("rr_duty_pre", duty, exp_duty(3));
        reset = 1'b1;
        #1;
        check_eq("rr_duty", duty, 0);
        check_eq("rr_dir", direction, IDLE);
        tick();
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
